sdram_pattern_tester: RTL and testbench

Client-side initiator for the SDRAM controller's request/ack interface. On `start` it writes a deterministic address-derived pattern to a contiguous word range, then reads the range back. Each read is compared against the expected pattern, and the block reports pass/fail, error count, first failing address/data and an access timeout. It sits between board-level start/status logic (button, LEDs, UART) and the SDRAM controller's client port in the sdramtest design.

---
 rtl/sdram_pattern_tester.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: writes exp(a) = a ^ SEED ^ inv_mask over a word range, reads it back and reports errors.
// Optional SDRAM_TESTER_LOOP_EN: passing runs restart with an inverted pattern and bump pass_cnt.
module sdram_pattern_tester #(
   parameter int unsigned BANK_WIDTH     = 2,
   parameter int unsigned ROW_WIDTH      = 13,
   parameter int unsigned COL_WIDTH      = 9,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned WORD_COUNT     = 4096,
   parameter int unsigned SEED           = 16'hA5C3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      pass,
   output logic                                      timeout,
   output logic [15:0]                               err_cnt,
   output logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] err_addr,
   output logic [DATA_WIDTH-1:0]                     err_data,
   output logic [15:0]                               pass_cnt,
   output logic                                      sdram_req,
   input  logic                                      sdram_ack,
   output logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] sdram_addr,
   output logic                                      sdram_rh_wl,
   output logic [DATA_WIDTH-1:0]                     sdram_data_w,
   input  logic [DATA_WIDTH-1:0]                     sdram_data_r,
   input  logic                                      sdram_data_r_en
);

   localparam int unsigned AW = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
   localparam int unsigned EW = (AW > DATA_WIDTH) ? AW : DATA_WIDTH;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AW-1:0]         LAST_ADDR = AW'(WORD_COUNT - 1);
   localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);
   localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_GAP  = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  rh_wl_q, rh_wl_d;
   logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
   logic                  req_q, req_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  timeout_q, timeout_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [AW-1:0]         err_addr_q, err_addr_d;
   logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [DATA_WIDTH-1:0] inv_mask_q;
   logic [15:0]           pass_cnt_q;
   logic [DATA_WIDTH-1:0] inv_next;
   logic                  rd_match;
   logic                  tmo_hit;
`ifdef SDRAM_TESTER_LOOP_EN
   logic [DATA_WIDTH-1:0] inv_mask_d;
   logic [15:0]           pass_cnt_d;
`endif

   function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [AW-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] inv);
      logic [EW-1:0] ext;
      ext = EW'(a);
      return ext[DATA_WIDTH-1:0] ^ SEED_W ^ inv;
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rh_wl_d    = rh_wl_q;
      data_w_d   = data_w_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      err_data_d = err_data_q;
      tmo_cnt_d  = tmo_cnt_q;
`ifdef SDRAM_TESTER_LOOP_EN
      inv_mask_d = inv_mask_q;
      pass_cnt_d = pass_cnt_q;
`endif
      rd_match = (sdram_data_r == exp_data(addr_q, inv_mask_q));
      tmo_hit  = (tmo_cnt_q == TMO_LAST);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               err_cnt_d  = '0;
               err_addr_d = '0;
               err_data_d = '0;
               timeout_d  = 1'b0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               addr_d     = '0;
               state_d    = S_WR_REQ;
`ifdef SDRAM_TESTER_LOOP_EN
               inv_mask_d = '0;
               pass_cnt_d = '0;
`endif
            end
         end
         S_WR_REQ: begin
            if (sdram_ack) begin
               state_d = S_WR_GAP;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_WR_GAP: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = S_RD_REQ;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = S_WR_REQ;
            end
         end
         S_RD_REQ: begin
            if (sdram_ack) begin
               state_d = S_RD_WAIT;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_RD_WAIT: begin
            if (sdram_data_r_en) begin
               if (!rd_match) begin
                  if (err_cnt_q != 16'hFFFF) begin
                     err_cnt_d = err_cnt_q + 16'd1;
                  end
                  if (err_cnt_q == '0) begin
                     err_addr_d = addr_q;
                     err_data_d = sdram_data_r;
                  end
               end
               if (addr_q == LAST_ADDR) begin
`ifdef SDRAM_TESTER_LOOP_EN
                  // A clean pass loops straight back into writing with the inverted pattern.
                  if (err_cnt_d == '0 && !timeout_q) begin
                     pass_cnt_d = pass_cnt_q + 16'd1;
                     inv_mask_d = ~inv_mask_q;
                     addr_d     = '0;
                     state_d    = S_WR_REQ;
                  end else begin
                     state_d = S_DONE;
                  end
`else
                  state_d = S_DONE;
`endif
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = S_RD_REQ;
               end
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef SDRAM_TESTER_LOOP_EN
      inv_next = inv_mask_d;
`else
      inv_next = inv_mask_q;
`endif

      // Address/command/data registers only move on entry to a request state.
      if (state_d != state_q) begin
         if (state_d == S_WR_REQ) begin
            rh_wl_d  = 1'b0;
            data_w_d = exp_data(addr_d, inv_next);
         end
         if (state_d == S_RD_REQ) begin
            rh_wl_d = 1'b1;
         end
         if (state_d == S_WR_REQ || state_d == S_RD_REQ || state_d == S_RD_WAIT) begin
            tmo_cnt_d = '0;
         end
         if (state_d == S_DONE) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0) && !timeout_d;
         end
      end else if (state_q == S_WR_REQ || state_q == S_RD_REQ || state_q == S_RD_WAIT) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end

      req_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rh_wl_q    <= 1'b0;
         data_w_q   <= '0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         err_data_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rh_wl_q    <= rh_wl_d;
         data_w_q   <= data_w_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         err_data_q <= err_data_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

`ifdef SDRAM_TESTER_LOOP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inv_mask_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         inv_mask_q <= inv_mask_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end
`else
   assign inv_mask_q = '0;
   assign pass_cnt_q = '0;
`endif

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;
   assign err_cnt      = err_cnt_q;
   assign err_addr     = err_addr_q;
   assign err_data     = err_data_q;
   assign pass_cnt     = pass_cnt_q;
   assign sdram_req    = req_q;
   assign sdram_addr   = addr_q;
   assign sdram_rh_wl  = rh_wl_q;
   assign sdram_data_w = data_w_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with WORD_COUNT=8, TIMEOUT_CYCLES=16 against a simple controller model.
module tb_sdram_pattern_tester;

   localparam int AW = 24;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done, pass, timeout;
   logic [15:0]   err_cnt;
   logic [AW-1:0] err_addr;
   logic [DW-1:0] err_data;
   logic [15:0]   pass_cnt;
   logic          sdram_req, sdram_ack, sdram_rh_wl, sdram_data_r_en;
   logic [AW-1:0] sdram_addr;
   logic [DW-1:0] sdram_data_w, sdram_data_r;

   int checks = 0;
   int failures = 0;

   // model state
   logic [15:0]   mem  [8];
   logic [15:0]   flip [8];
   bit            withhold_en = 1'b0;
   logic [AW-1:0] withhold_addr = '0;
   int            req_cnt = 0;
   int            viol_cnt = 0;
   logic [AW-1:0] wr_addr_log [$];
   logic [15:0]   wr_data_log [$];
   logic [AW-1:0] rd_addr_log [$];

   logic [15:0] exp_tab [8] = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0,
                                16'hA5C7, 16'hA5C6, 16'hA5C5, 16'hA5C4};

   always #5 clk = ~clk;

   sdram_pattern_tester #(
      .WORD_COUNT(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .busy(busy),
      .done(done),
      .pass(pass),
      .timeout(timeout),
      .err_cnt(err_cnt),
      .err_addr(err_addr),
      .err_data(err_data),
      .pass_cnt(pass_cnt),
      .sdram_req(sdram_req),
      .sdram_ack(sdram_ack),
      .sdram_addr(sdram_addr),
      .sdram_rh_wl(sdram_rh_wl),
      .sdram_data_w(sdram_data_w),
      .sdram_data_r(sdram_data_r),
      .sdram_data_r_en(sdram_data_r_en)
   );

   // Controller model: ack 2 cycles after seeing req, read data 3 cycles after ack.
   initial begin : model
      int ack_wait;
      int data_wait;
      bit prev_req;
      logic [AW-1:0] rd_a;
      ack_wait = 0;
      data_wait = 0;
      prev_req = 1'b0;
      rd_a = '0;
      sdram_ack = 1'b0;
      sdram_data_r_en = 1'b0;
      sdram_data_r = '0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      forever begin
         @(posedge clk);
         #1;
         if (sdram_ack && sdram_req) viol_cnt++;
         if (sdram_req && !prev_req) req_cnt++;
         prev_req = sdram_req;
         sdram_ack = 1'b0;
         sdram_data_r_en = 1'b0;
         if (data_wait > 0) begin
            data_wait--;
            if (data_wait == 0) begin
               sdram_data_r_en = 1'b1;
               sdram_data_r = mem[rd_a[2:0]] ^ flip[rd_a[2:0]];
            end
         end
         if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) begin
               sdram_ack = 1'b1;
               if (!sdram_rh_wl) begin
                  mem[sdram_addr[2:0]] = sdram_data_w;
                  wr_addr_log.push_back(sdram_addr);
                  wr_data_log.push_back(sdram_data_w);
               end else begin
                  rd_a = sdram_addr;
                  data_wait = 3;
                  rd_addr_log.push_back(sdram_addr);
               end
            end
         end else if (sdram_req && !(withhold_en && !sdram_rh_wl && sdram_addr == withhold_addr)) begin
            ack_wait = 2;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, done, pass, timeout, sdram_req, sdram_rh_wl} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000", {busy, done, pass, timeout, sdram_req, sdram_rh_wl});
      end
      checks++;
      if ({err_cnt, err_addr, err_data, pass_cnt, sdram_addr, sdram_data_w} !== '0) begin
         failures++;
         $display("FAIL reset_vectors got err_cnt=%h err_addr=%h err_data=%h pass_cnt=%h addr=%h data_w=%h exp=0",
                  err_cnt, err_addr, err_data, pass_cnt, sdram_addr, sdram_data_w);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_pass;
      int wb, rb, rq, vb;
      bit ok;
      wb = wr_addr_log.size();
      rb = rd_addr_log.size();
      rq = req_cnt;
      vb = viol_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, sdram_req, sdram_rh_wl} !== 3'b110 || sdram_addr !== '0 || sdram_data_w !== 16'hA5C3) begin
         failures++;
         $display("FAIL first_req got busy=%b req=%b rh_wl=%b addr=%h data=%h exp 1 1 0 0 a5c3",
                  busy, sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w);
      end
      wait_done(400, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL pass_done_wait got done=%b exp=1", done);
      end
      checks++;
      if ({done, pass, timeout, busy} !== 4'b1100 || err_cnt !== 16'd0) begin
         failures++;
         $display("FAIL pass_status got done=%b pass=%b timeout=%b busy=%b err_cnt=%0d exp 1 1 0 0 0",
                  done, pass, timeout, busy, err_cnt);
      end
      checks++;
      if (wr_addr_log.size() - wb !== 8 || rd_addr_log.size() - rb !== 8) begin
         failures++;
         $display("FAIL access_count got wr=%0d rd=%0d exp 8 8", wr_addr_log.size() - wb, rd_addr_log.size() - rb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_addr_log[wb+i] !== AW'(i) || wr_data_log[wb+i] !== exp_tab[i] || rd_addr_log[rb+i] !== AW'(i)) begin
               failures++;
               $display("FAIL write_%0d got wa=%h wd=%h ra=%h exp %h %h %h",
                        i, wr_addr_log[wb+i], wr_data_log[wb+i], rd_addr_log[rb+i], i, exp_tab[i], i);
            end
         end
      end
      checks++;
      if (req_cnt - rq !== 16) begin
         failures++;
         $display("FAIL req_pulses got=%0d exp=16", req_cnt - rq);
      end
      checks++;
      if (viol_cnt - vb !== 0) begin
         failures++;
         $display("FAIL req_after_ack got=%0d exp=0", viol_cnt - vb);
      end
      checks++;
      if (pass_cnt !== 16'd0) begin
         failures++;
         $display("FAIL pass_cnt_single got=%0d exp=0", pass_cnt);
      end
   endtask

   task automatic test_single_error;
      bit ok;
      flip[5] = 16'h0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, ok);
      checks++;
      if (!ok || {done, pass} !== 2'b10 || err_cnt !== 16'd1 || err_addr !== AW'(5) || err_data !== 16'hA5C7) begin
         failures++;
         $display("FAIL single_error got done=%b pass=%b cnt=%0d addr=%h data=%h exp 1 0 1 5 a5c7",
                  done, pass, err_cnt, err_addr, err_data);
      end
      flip[5] = 16'h0000;
   endtask

   task automatic test_double_error;
      bit ok;
      flip[2] = 16'h0100;
      flip[6] = 16'h0100;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, ok);
      checks++;
      if (!ok || {done, pass} !== 2'b10 || err_cnt !== 16'd2 || err_addr !== AW'(2) || err_data !== 16'hA4C1) begin
         failures++;
         $display("FAIL double_error got done=%b pass=%b cnt=%0d addr=%h data=%h exp 1 0 2 2 a4c1",
                  done, pass, err_cnt, err_addr, err_data);
      end
      flip[2] = 16'h0000;
      flip[6] = 16'h0000;
   endtask

   task automatic test_timeout;
      int wb, rb, n;
      bit seen;
      wb = wr_addr_log.size();
      rb = rd_addr_log.size();
      withhold_addr = AW'(2);
      withhold_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (sdram_req && !sdram_rh_wl && sdram_addr == AW'(2)) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n = 0;
      if (seen) begin
         while (!timeout && n < 100) begin
            tick();
            n++;
         end
      end
      checks++;
      if (!seen || n !== 16) begin
         failures++;
         $display("FAIL timeout_latency got seen=%b cycles=%0d exp 1 16", seen, n);
      end
      checks++;
      if ({timeout, sdram_req, done, pass, busy} !== 5'b10100) begin
         failures++;
         $display("FAIL timeout_status got to=%b req=%b done=%b pass=%b busy=%b exp 1 0 1 0 0",
                  timeout, sdram_req, done, pass, busy);
      end
      checks++;
      if (wr_addr_log.size() - wb !== 2 || rd_addr_log.size() - rb !== 0) begin
         failures++;
         $display("FAIL timeout_accesses got wr=%0d rd=%0d exp 2 0", wr_addr_log.size() - wb, rd_addr_log.size() - rb);
      end
      withhold_en = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_held_start;
      bit ok;
      int rq0, rq1;
      start = 1'b1;
      tick();
      wait_done(400, ok);
      checks++;
      if (!ok || pass !== 1'b1 || timeout !== 1'b0 || err_cnt !== 16'd0) begin
         failures++;
         $display("FAIL held_first got done=%b pass=%b to=%b cnt=%0d exp 1 1 0 0", done, pass, timeout, err_cnt);
      end
      for (int r = 0; r < 2; r++) begin
         rq0 = req_cnt;
         for (int i = 0; i < 5 && done; i++) tick();
         wait_done(400, ok);
         rq1 = req_cnt;
         checks++;
         if (!ok || rq1 - rq0 !== 16 || pass !== 1'b1) begin
            failures++;
            $display("FAIL held_run_%0d got done=%b reqs=%0d pass=%b exp 1 16 1", r, done, rq1 - rq0, pass);
         end
      end
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if ({done, busy, sdram_req} !== 3'b100) begin
         failures++;
         $display("FAIL held_stop got done=%b busy=%b req=%b exp 1 0 0", done, busy, sdram_req);
      end
   endtask

   task automatic test_reset_mid_read;
      bit seen, ok;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (sdram_req && sdram_rh_wl) begin
            seen = 1'b1;
            break;
         end
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (!seen || {busy, done, pass, timeout, sdram_req, sdram_rh_wl} !== 6'b0 ||
          {err_cnt, err_addr, err_data, pass_cnt, sdram_addr, sdram_data_w} !== '0) begin
         failures++;
         $display("FAIL reset_mid_read got seen=%b busy=%b req=%b rh_wl=%b addr=%h data=%h exp 1 0 0 0 0 0",
                  seen, busy, sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w);
      end
      repeat (3) tick();
      reset = 1'b0;
      repeat (10) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, ok);
      checks++;
      if (!ok || pass !== 1'b1 || err_cnt !== 16'd0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_pass got done=%b pass=%b cnt=%0d to=%b exp 1 1 0 0", done, pass, err_cnt, timeout);
      end
   endtask

`ifdef SDRAM_TESTER_LOOP_EN
   task automatic test_loop;
      int wb;
      bit seen_done, reached;
      wb = wr_addr_log.size();
      start = 1'b1;
      tick();
      start = 1'b0;
      seen_done = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (done) seen_done = 1'b1;
         if (pass_cnt == 16'd2) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached || seen_done || busy !== 1'b1) begin
         failures++;
         $display("FAIL loop_passes got cnt=%0d done_seen=%b busy=%b exp 2 0 1", pass_cnt, seen_done, busy);
      end
      checks++;
      if (wr_addr_log.size() - wb < 9 || wr_addr_log[wb+8] !== '0 || wr_data_log[wb+8] !== 16'h5A3C) begin
         failures++;
         $display("FAIL loop_inverted got n=%0d exp addr 0 data 5a3c", wr_addr_log.size() - wb);
      end
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (10) tick();
   endtask
`endif

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) flip[i] = '0;
      test_reset();
      test_single_pass();
      test_single_error();
      test_double_error();
      test_timeout();
      test_held_start();
      test_reset_mid_read();
`ifdef SDRAM_TESTER_LOOP_EN
      test_loop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
